// File: rtl/counter8_ctrl.sv
//==============================================================================
// counter8_ctrl: command decoder, state register and count register for the
// 8-bit up/down counter. The optional macro CNT8_SAT_EN selects saturating count.
// Revision: 1.0
//==============================================================================
`default_nettype none

module counter8_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] d_in,
  output logic [2:0] state,
  output logic [7:0] cnt,
  output logic       zero,
  output logic       wrap
);

  typedef enum logic [2:0] {
    IDLE_STATE = 3'b000,
    LOAD_STATE = 3'b001,
    INC_STATE  = 3'b010,
    INC2_STATE = 3'b011,
    DEC_STATE  = 3'b100,
    DEC2_STATE = 3'b101,
    HOLD_STATE = 3'b110
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wrap_q, wrap_d;
  logic       inc_only, dec_only;
  logic [8:0] cnt_inc, cnt_dec;

  always_comb begin
    inc_only = inc & ~dec;
    dec_only = dec & ~inc;
    state_d  = HOLD_STATE;

    if (state_q == IDLE_STATE || state_q == LOAD_STATE || state_q == INC_STATE ||
        state_q == INC2_STATE || state_q == DEC_STATE  || state_q == DEC2_STATE ||
        state_q == HOLD_STATE) begin
      if (clr) begin
        state_d = IDLE_STATE;
      end else if (load) begin
        state_d = LOAD_STATE;
      end else if (inc_only) begin
        state_d = (state_q == INC_STATE || state_q == INC2_STATE) ? INC2_STATE : INC_STATE;
      end else if (dec_only) begin
        state_d = (state_q == DEC_STATE || state_q == DEC2_STATE) ? DEC2_STATE : DEC_STATE;
      end else begin
        state_d = (state_q == IDLE_STATE) ? IDLE_STATE : HOLD_STATE;
      end
    end else begin
      // Unused code 3'b111 recovers to IDLE regardless of commands
      state_d = IDLE_STATE;
    end
  end

  always_comb begin
    // The 9th bit carries out on FF+1 and borrows on 00-1
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    cnt_dec = {1'b0, cnt_q} - 9'd1;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    case (state_d)
      IDLE_STATE: cnt_d = 8'h00;
      LOAD_STATE: cnt_d = d_in;
      INC_STATE, INC2_STATE: begin
        wrap_d = cnt_inc[8];
`ifdef CNT8_SAT_EN
        cnt_d  = cnt_inc[8] ? cnt_q : cnt_inc[7:0];
`else
        cnt_d  = cnt_inc[7:0];
`endif
      end
      DEC_STATE, DEC2_STATE: begin
        wrap_d = cnt_dec[8];
`ifdef CNT8_SAT_EN
        cnt_d  = cnt_dec[8] ? cnt_q : cnt_dec[7:0];
`else
        cnt_d  = cnt_dec[7:0];
`endif
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_STATE;
      cnt_q   <= 8'h00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign wrap  = wrap_q;
  assign zero  = (cnt_q == 8'h00);

endmodule

`default_nettype wire

// File: tb/tb_counter8_ctrl.sv
// Self-checking bench for counter8_ctrl: directed scenarios plus randomized
// commands against a run-length based reference model.
`default_nettype none

module tb_counter8_ctrl;

`ifdef CNT8_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_INC = 3'd2, S_INC2 = 3'd3,
                         S_DEC = 3'd4, S_DEC2 = 3'd5, S_HOLD = 3'd6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [2:0] state;
  logic [7:0] cnt;
  logic       zero, wrap;

  int checks = 0;
  int failures = 0;

  // Reference model: state derived from run lengths, count as plain integer
  logic [2:0] m_state;
  int         m_cnt, inc_run, dec_run;
  logic       m_wrap;

  always #5 clk = ~clk;

  counter8_ctrl dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .inc(inc), .dec(dec),
    .d_in(d_in), .state(state), .cnt(cnt), .zero(zero), .wrap(wrap)
  );

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_wrap = 1'b0; inc_run = 0; dec_run = 0;
  endtask

  task automatic model_step(input logic c, input logic l, input logic i, input logic d,
                            input logic [7:0] din);
    int nxt;
    m_wrap = 1'b0;
    if (c) begin
      m_state = S_IDLE; m_cnt = 0; inc_run = 0; dec_run = 0;
    end else if (l) begin
      m_state = S_LOAD; m_cnt = int'(din); inc_run = 0; dec_run = 0;
    end else if (i && !d) begin
      inc_run++; dec_run = 0;
      m_state = (inc_run >= 2) ? S_INC2 : S_INC;
      nxt = m_cnt + 1;
      if (nxt > 255) begin m_wrap = 1'b1; nxt = SAT ? 255 : 0; end
      m_cnt = nxt;
    end else if (d && !i) begin
      dec_run++; inc_run = 0;
      m_state = (dec_run >= 2) ? S_DEC2 : S_DEC;
      nxt = m_cnt - 1;
      if (nxt < 0) begin m_wrap = 1'b1; nxt = SAT ? 0 : 255; end
      m_cnt = nxt;
    end else begin
      inc_run = 0; dec_run = 0;
      if (m_state != S_IDLE) m_state = S_HOLD;
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input logic c, input logic l, input logic i, input logic d,
                       input logic [7:0] din);
    @(negedge clk);
    clr = c; load = l; inc = i; dec = d; d_in = din;
    @(posedge clk);
    #1;
    model_step(c, l, i, d, din);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== S_IDLE || cnt !== 8'h00 || zero !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got st=%0d cnt=%h z=%b w=%b exp st=0 cnt=00 z=1 w=0",
               state, cnt, zero, wrap);
    end
    reset_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (state !== S_IDLE || cnt !== 8'h00 || zero !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got st=%0d cnt=%h z=%b w=%b exp st=0 cnt=00 z=1 w=0",
               state, cnt, zero, wrap);
    end
  endtask

  task automatic test_load_count();
    logic [2:0] exp_st [3] = '{S_INC, S_INC2, S_INC2};
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    checks++;
    if (state !== S_LOAD || cnt !== 8'h10) begin
      failures++;
      $display("FAIL load got st=%0d cnt=%h exp st=1 cnt=10", state, cnt);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (state !== exp_st[k] || cnt !== 8'(8'h11 + k)) begin
        failures++;
        $display("FAIL inc_run%0d got st=%0d cnt=%h exp st=%0d cnt=%h",
                 k, state, cnt, exp_st[k], 8'(8'h11 + k));
      end
    end
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (cnt !== 8'hFF || wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_step1 got cnt=%h w=%b exp cnt=ff w=0", cnt, wrap);
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (cnt !== (SAT ? 8'hFF : 8'h00) || wrap !== 1'b1 || zero !== !SAT) begin
      failures++;
      $display("FAIL wrap_step2 got cnt=%h w=%b z=%b exp cnt=%h w=1 z=%b",
               cnt, wrap, zero, SAT ? 8'hFF : 8'h00, !SAT);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (wrap !== 1'b0 || state !== S_HOLD) begin
      failures++;
      $display("FAIL wrap_pulse_end got w=%b st=%0d exp w=0 st=6", wrap, state);
    end
  endtask

  task automatic test_dec_zero();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (cnt !== (SAT ? 8'h00 : 8'hFF) || wrap !== 1'b1 || state !== S_DEC) begin
      failures++;
      $display("FAIL dec_zero got cnt=%h w=%b st=%0d exp cnt=%h w=1 st=4",
               cnt, wrap, state, SAT ? 8'h00 : 8'hFF);
    end
  endtask

  task automatic test_priority();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    checks++;
    if (state !== S_LOAD || cnt !== 8'h5A) begin
      failures++;
      $display("FAIL prio_load got st=%0d cnt=%h exp st=1 cnt=5a", state, cnt);
    end
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++;
    if (state !== S_HOLD || cnt !== 8'h5A) begin
      failures++;
      $display("FAIL prio_incdec got st=%0d cnt=%h exp st=6 cnt=5a", state, cnt);
    end
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    checks++;
    if (state !== S_IDLE || cnt !== 8'h00 || zero !== 1'b1) begin
      failures++;
      $display("FAIL prio_clr got st=%0d cnt=%h z=%b exp st=0 cnt=00 z=1", state, cnt, zero);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, k[0] == 1'b0, k[0] == 1'b1, 8'h00);
      checks++;
      if (state !== (k[0] ? S_DEC : S_INC) || cnt !== (k[0] ? 8'h80 : 8'h81)) begin
        failures++;
        $display("FAIL alt%0d got st=%0d cnt=%h exp st=%0d cnt=%h", k, state, cnt,
                 k[0] ? S_DEC : S_INC, k[0] ? 8'h80 : 8'h81);
      end
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (state !== S_INC || cnt !== 8'h21) begin
      failures++;
      $display("FAIL load_breaks_run got st=%0d cnt=%h exp st=2 cnt=21", state, cnt);
    end
  endtask

  task automatic test_mid_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (7) apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (cnt !== 8'h07 || state !== S_INC2) begin
      failures++;
      $display("FAIL pre_reset_run got st=%0d cnt=%h exp st=3 cnt=07", state, cnt);
    end
    @(negedge clk);
    inc = 1'b0;
    reset_n = 1'b0;
    #2;
    checks++;
    if (state !== S_IDLE || cnt !== 8'h00 || zero !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got st=%0d cnt=%h z=%b w=%b exp st=0 cnt=00 z=1 w=0",
               state, cnt, zero, wrap);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (state !== S_INC || cnt !== 8'h01) begin
      failures++;
      $display("FAIL post_reset_inc got st=%0d cnt=%h exp st=2 cnt=01", state, cnt);
    end
  endtask

  task automatic test_random();
    logic c, l, i, d;
    logic [7:0] din;
    int r;
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 99));
      c   = (r < 5);
      l   = (r >= 5 && r < 15) || ($urandom_range(0, 19) == 0);
      i   = $urandom_range(0, 1) == 1;
      d   = $urandom_range(0, 2) == 0;
      // Bias loads toward the wrap boundaries
      din = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                        : 8'($urandom);
      apply(c, l, i, d, din);
      checks++;
      if (state !== m_state || cnt !== 8'(m_cnt) || wrap !== m_wrap ||
          zero !== (m_cnt == 0)) begin
        failures++;
        $display("FAIL random%0d got st=%0d cnt=%h w=%b z=%b exp st=%0d cnt=%h w=%b z=%b",
                 n, state, cnt, wrap, zero, m_state, 8'(m_cnt), m_wrap, m_cnt == 0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_count();
    test_wrap();
    test_dec_zero();
    test_priority();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
